// File: rtl/ofmap_store_ctrl_if.sv
// ofmap_store_ctrl_if
//  Bundles the writeback dual-port input stream, the single-port SRAM write
//  bus and the status flags of ofmap_store_ctrl.
//  master: the side that drives start/in_* and observes the SRAM bus and status.
//  slave : the store controller itself.
//  Signals:
//   start                      1-cycle pulse, begin (or restart) a feature map
//   in_data0/in_valid0         even-row value of the current pair
//   in_data1/in_valid1         odd-row value of the current pair
//   mem_we/mem_addr/mem_wdata  SRAM write port
//   busy/done/overflow         status: active, map complete pulse, sticky drop flag
interface ofmap_store_ctrl_if #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic [DATA_W-1:0] in_data0;
    logic              in_valid0;
    logic [DATA_W-1:0] in_data1;
    logic              in_valid1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, in_data0, in_valid0, in_data1, in_valid1,
        input  mem_we, mem_addr, mem_wdata, busy, done, overflow
    );

    modport slave (
        input  start, in_data0, in_valid0, in_data1, in_valid1,
        output mem_we, mem_addr, mem_wdata, busy, done, overflow
    );
endinterface

// File: rtl/ofmap_store_ctrl.sv
// ofmap_store_ctrl
//  Serialises port0/port1 row pairs from the conv writeback stream into one
//  single-write-port ofmap SRAM. Each value is tagged with its SRAM address,
//  pushed (up to two per cycle) into a FIFO and drained one word per cycle.
//  done pulses once ROWS rows have been addressed and the FIFO has drained.
//  Optional feature: define OFMAP_RELU_EN to clamp negative values to 0 before
//  the push; otherwise data is stored bit-exact.
//  Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active-low
//   bus    ofmap_store_ctrl_if.slave (start, in_*, mem_*, busy, done, overflow)
module ofmap_store_ctrl #(
    parameter int unsigned DATA_W     = 25,
    parameter int unsigned DEPTH      = 46,
    parameter int unsigned ROWS       = 46,
    parameter int unsigned FIFO_DEPTH = 128,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    ofmap_store_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned COL_W = $clog2(DEPTH + 1);
    localparam int unsigned ROW_W = $clog2(ROWS + 3) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_done_nxt;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row_cnt;
    logic [ADDR_W-1:0] r_row_off;
    logic              r_seen0;
    logic              r_seen1;

    entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic              w_run;
    logic              w_v0;
    logic              w_v1;
    logic              w_any;
    logic              w_seen0;
    logic              w_seen1;
    logic              w_adv;
    logic              w_two;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic [DATA_W-1:0] w_data0;
    logic [DATA_W-1:0] w_data1;
    entry_t            w_ent0;
    entry_t            w_ent1;
    logic [CNT_W-1:0]  w_free;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_drop;
    logic              w_pop;
    logic [CNT_W-1:0]  w_npush;
    logic [PTR_W-1:0]  w_wptr1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; start restarts the map from any state
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (bus.start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_RUN:   if (r_row_cnt >= ROW_W'(ROWS)) w_state_nxt = S_FLUSH;
                S_FLUSH: if (r_count == '0) begin
                             w_state_nxt = S_IDLE;
                             w_done_nxt  = 1'b1;
                         end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Burst tracking: inputs only count in RUN and never in a start cycle
    assign w_run   = (r_state == S_RUN) && !bus.start;
    assign w_v0    = w_run && bus.in_valid0;
    assign w_v1    = w_run && bus.in_valid1;
    assign w_any   = w_v0 || w_v1;
    assign w_seen0 = r_seen0 || w_v0;
    assign w_seen1 = r_seen1 || w_v1;
    // Rows advance on a column wrap inside a burst, or on the first idle cycle after one
    assign w_adv   = w_any ? (r_col == COL_W'(DEPTH - 1)) : (w_run && (r_seen0 || r_seen1));
    assign w_two   = w_any ? (w_seen0 && w_seen1) : (r_seen0 && r_seen1);
    assign w_addr0 = r_row_off + ADDR_W'(r_col);
    assign w_addr1 = w_addr0 + ADDR_W'(DEPTH);

    // Optional ReLU on the pushed values
    always_comb begin
        w_data0 = bus.in_data0;
        w_data1 = bus.in_data1;
`ifdef OFMAP_RELU_EN
        if (bus.in_data0[DATA_W-1]) w_data0 = '0;
        if (bus.in_data1[DATA_W-1]) w_data1 = '0;
`endif
    end

    assign w_ent0 = {w_addr0, w_data0};
    assign w_ent1 = {w_addr1, w_data1};

    // FIFO admission: port0 takes the last free slot, port1 is the one dropped
    assign w_free  = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_acc0  = w_v0 && (w_free != '0);
    assign w_acc1  = w_v1 && (w_free >= (w_acc0 ? CNT_W'(2) : CNT_W'(1)));
    assign w_drop  = (w_v0 && !w_acc0) || (w_v1 && !w_acc1);
    assign w_pop   = (r_count != '0) && !bus.start;
    assign w_npush = CNT_W'(w_acc0) + CNT_W'(w_acc1);
    assign w_wptr1 = r_wptr + PTR_W'(1);

    // FIFO storage; port1 lands behind port0 when both are accepted
    always_ff @(posedge clk) begin
        if (w_acc0) r_mem[r_wptr] <= w_ent0;
        if (w_acc1) r_mem[w_acc0 ? w_wptr1 : r_wptr] <= w_ent1;
    end

    // Counters, FIFO pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row_cnt   <= '0;
            r_row_off   <= '0;
            r_seen0     <= 1'b0;
            r_seen1     <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_done_nxt;
            if (bus.start) begin
                r_col      <= '0;
                r_row_cnt  <= '0;
                r_row_off  <= '0;
                r_seen0    <= 1'b0;
                r_seen1    <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_mem_we   <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                r_mem_we <= w_pop;
                if (w_pop) begin
                    r_mem_addr  <= r_mem[r_rptr].addr;
                    r_mem_wdata <= r_mem[r_rptr].data;
                    r_rptr      <= r_rptr + PTR_W'(1);
                end
                r_wptr  <= r_wptr + PTR_W'(w_npush);
                r_count <= r_count + w_npush - CNT_W'(w_pop);
                if (w_drop) r_overflow <= 1'b1;

                if (w_adv) begin
                    r_col     <= '0;
                    r_seen0   <= 1'b0;
                    r_seen1   <= 1'b0;
                    r_row_cnt <= r_row_cnt + (w_two ? ROW_W'(2) : ROW_W'(1));
                    r_row_off <= r_row_off + (w_two ? ADDR_W'(2 * DEPTH) : ADDR_W'(DEPTH));
                end else if (w_any) begin
                    r_col   <= r_col + COL_W'(1);
                    r_seen0 <= w_seen0;
                    r_seen1 <= w_seen1;
                end else begin
                    r_col <= '0;
                end
            end
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_ofmap_store_ctrl.sv
// tb_ofmap_store_ctrl
//  Three instances share one stimulus stream:
//   u_main ROWS=4 FIFO_DEPTH=128, u_tail ROWS=3 FIFO_DEPTH=128, u_ovf ROWS=4 FIFO_DEPTH=32.
//  A negedge monitor logs every SRAM write and done pulse per instance.
module tb_ofmap_store_ctrl;
    localparam int unsigned DATA_W = 25;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 46;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              tb_start = 1'b0;
    logic              tb_v0    = 1'b0;
    logic              tb_v1    = 1'b0;
    logic [DATA_W-1:0] tb_d0    = '0;
    logic [DATA_W-1:0] tb_d1    = '0;

    ofmap_store_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_m ();
    ofmap_store_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_t ();
    ofmap_store_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_o ();

    assign if_m.start = tb_start; assign if_m.in_valid0 = tb_v0; assign if_m.in_data0 = tb_d0;
    assign if_m.in_valid1 = tb_v1; assign if_m.in_data1 = tb_d1;
    assign if_t.start = tb_start; assign if_t.in_valid0 = tb_v0; assign if_t.in_data0 = tb_d0;
    assign if_t.in_valid1 = tb_v1; assign if_t.in_data1 = tb_d1;
    assign if_o.start = tb_start; assign if_o.in_valid0 = tb_v0; assign if_o.in_data0 = tb_d0;
    assign if_o.in_valid1 = tb_v1; assign if_o.in_data1 = tb_d1;

    ofmap_store_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(4), .FIFO_DEPTH(128), .ADDR_W(ADDR_W))
        u_main (.clk(clk), .rst_n(rst_n), .bus(if_m));
    ofmap_store_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(3), .FIFO_DEPTH(128), .ADDR_W(ADDR_W))
        u_tail (.clk(clk), .rst_n(rst_n), .bus(if_t));
    ofmap_store_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(4), .FIFO_DEPTH(32), .ADDR_W(ADDR_W))
        u_ovf  (.clk(clk), .rst_n(rst_n), .bus(if_o));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int                wcnt [3];
    int                dcnt [3];
    int                last_wr_cyc [3];
    int                done_cyc [3];
    int                hits [3][256];
    logic [DATA_W-1:0] wdat [3][256];
    int                seq_addr [$];
    logic [DATA_W-1:0] seq_data [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic log_ev(input int j, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic dn);
        if (we === 1'b1) begin
            wcnt[j]++;
            last_wr_cyc[j] = cyc;
            if (int'(a) < 256) begin
                hits[j][int'(a)]++;
                wdat[j][int'(a)] = d;
            end
            if (j == 0) begin
                seq_addr.push_back(int'(a));
                seq_data.push_back(d);
            end
        end
        if (dn === 1'b1) begin
            dcnt[j]++;
            done_cyc[j] = cyc;
        end
    endtask

    always @(negedge clk) begin
        log_ev(0, if_m.mem_we, if_m.mem_addr, if_m.mem_wdata, if_m.done);
        log_ev(1, if_t.mem_we, if_t.mem_addr, if_t.mem_wdata, if_t.done);
        log_ev(2, if_o.mem_we, if_o.mem_addr, if_o.mem_wdata, if_o.done);
    end

    task automatic clear_logs();
        for (int j = 0; j < 3; j++) begin
            wcnt[j] = 0; dcnt[j] = 0; last_wr_cyc[j] = 0; done_cyc[j] = 0;
            for (int a = 0; a < 256; a++) begin
                hits[j][a] = 0;
                wdat[j][a] = '0;
            end
        end
        seq_addr.delete();
        seq_data.delete();
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int q_addr(input int i);
        return (i < seq_addr.size()) ? seq_addr[i] : -1;
    endfunction

    function automatic logic [DATA_W-1:0] q_data(input int i);
        return (i < seq_data.size()) ? seq_data[i] : {DATA_W{1'bx}};
    endfunction

    // Hand-derived stored value for a pushed input under the current build
    function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] d);
`ifdef OFMAP_RELU_EN
        return d[DATA_W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [DATA_W-1:0] d1);
        tb_v0 = v0; tb_d0 = d0; tb_v1 = v1; tb_d1 = d1;
        step();
    endtask

    task automatic idle(input int n);
        tb_v0 = 1'b0; tb_v1 = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_start();
        tb_start = 1'b1;
        step();
        tb_start = 1'b0;
    endtask

    task automatic burst(input int len, input logic v0, input logic v1, input int b0, input int b1);
        for (int c = 0; c < len; c++) drive(v0, DATA_W'(b0 + c), v1, DATA_W'(b1 + c));
        tb_v0 = 1'b0; tb_v1 = 1'b0;
    endtask

    // Every address in lo..hi written exp_hits times; when once, with data dbase+offset
    task automatic check_range(input string nm, input int j, input int lo, input int hi,
                               input int exp_hits, input int dbase);
        int bad;
        bad = 0;
        for (int a = lo; a <= hi; a++) begin
            if (hits[j][a] != exp_hits) bad++;
            else if (exp_hits == 1 && wdat[j][a] !== DATA_W'(dbase + a - lo)) bad++;
        end
        check(nm, 64'(bad), 64'd0);
    endtask

    task automatic wait_done(input string nm, input int j, input int budget);
        int n;
        n = 0;
        while (dcnt[j] == 0 && n < budget) begin
            step();
            n++;
        end
        check(nm, 64'(dcnt[j] > 0), 64'd1);
    endtask

    typedef struct {
        logic              v0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [DATA_W-1:0] d1;
        int                n;
        int                a_first;
        logic [DATA_W-1:0] x_first;
        int                a_second;
        logic [DATA_W-1:0] x_second;
        int                a_next;
    } vec_t;

    vec_t vt [6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // One-cycle bursts: first writes, then a port0 probe after one idle cycle
        vt[0] = '{1'b1, 25'd5,       1'b0, 25'd0,       1, 0, 25'd5,       -1, '0, 46};
        vt[1] = '{1'b0, 25'd0,       1'b1, 25'd9,       1, 46, 25'd9,      -1, '0, 46};
        vt[2] = '{1'b1, 25'd3,       1'b1, 25'd4,       2, 0, 25'd3,       46, 25'd4, 92};
        vt[3] = '{1'b1, 25'h1FFFFFB, 1'b0, 25'd0,       1, 0, stored(25'h1FFFFFB), -1, '0, 46};
        vt[4] = '{1'b1, 25'd7,       1'b1, 25'h1FFFFFF, 2, 0, 25'd7,       46, stored(25'h1FFFFFF), 92};
        vt[5] = '{1'b1, 25'h0FFFFFF, 1'b1, 25'h1000000, 2, 0, 25'h0FFFFFF, 46, stored(25'h1000000), 92};

        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_we",    64'(if_m.mem_we),    64'd0);
        check("reset_mem_addr",  64'(if_m.mem_addr),  64'd0);
        check("reset_mem_wdata", 64'(if_m.mem_wdata), 64'd0);
        check("reset_busy",      64'(if_m.busy),      64'd0);
        check("reset_done",      64'(if_m.done),      64'd0);
        check("reset_overflow",  64'(if_m.overflow),  64'd0);
        rst_n = 1'b1;
        step();

        // Inputs outside RUN are ignored
        burst(4, 1'b1, 1'b1, 1, 2);
        idle(4);
        check("idle_ignores_inputs", 64'(wcnt[0]), 64'd0);

        do_start();
        check("busy_after_start", 64'(if_m.busy), 64'd1);

        // Table-driven single-cycle pairs
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            do_start();
            drive(vt[i].v0, vt[i].d0, vt[i].v1, vt[i].d1);
            idle(1);
            drive(1'b1, 25'h55, 1'b0, 25'd0);
            idle(6);
            check($sformatf("vec%0d_count", i), 64'(wcnt[0]), 64'(vt[i].n + 1));
            check($sformatf("vec%0d_addr0", i), 64'(q_addr(0)), 64'(vt[i].a_first));
            check($sformatf("vec%0d_data0", i), 64'(q_data(0)), 64'(vt[i].x_first));
            if (vt[i].n == 2) begin
                check($sformatf("vec%0d_addr1", i), 64'(q_addr(1)), 64'(vt[i].a_second));
                check($sformatf("vec%0d_data1", i), 64'(q_data(1)), 64'(vt[i].x_second));
            end
            check($sformatf("vec%0d_next_addr", i), 64'(q_addr(vt[i].n)), 64'(vt[i].a_next));
            check($sformatf("vec%0d_hold_addr", i), 64'(if_m.mem_addr), 64'(vt[i].a_next));
            check($sformatf("vec%0d_hold_data", i), 64'(if_m.mem_wdata), 64'h55);
        end

        // Pop latency: sampled at edge N, written in the cycle after edge N+1
        clear_logs();
        do_start();
        drive(1'b1, 25'd42, 1'b0, 25'd0);
        tb_v0 = 1'b0;
        @(negedge clk);
        check("lat_we_n0", 64'(if_m.mem_we), 64'd0);
        @(negedge clk);
        check("lat_we_n1", 64'(if_m.mem_we), 64'd1);
        check("lat_addr",  64'(if_m.mem_addr), 64'd0);
        check("lat_data",  64'(if_m.mem_wdata), 64'd42);
        @(negedge clk);
        check("lat_we_n2", 64'(if_m.mem_we), 64'd0);
        check("lat_hold",  64'(if_m.mem_wdata), 64'd42);
        step();

        // One full dual burst
        clear_logs();
        do_start();
        burst(DEPTH, 1'b1, 1'b1, 0, 100);
        idle(70);
        check("pair_count", 64'(wcnt[0]), 64'd92);
        check_range("pair_port0", 0, 0, 45, 1, 0);
        check_range("pair_port1", 0, 46, 91, 1, 100);
        check("pair_order", 64'({q_addr(0)[7:0], q_addr(1)[7:0], q_addr(2)[7:0], q_addr(3)[7:0]}),
              64'({8'd0, 8'd46, 8'd1, 8'd47}));
        check("pair_still_busy", 64'(if_m.busy), 64'd1);
        check("pair_no_done", 64'(dcnt[0]), 64'd0);

        // Two dual bursts with one idle cycle between: full 4-row map
        clear_logs();
        do_start();
        burst(DEPTH, 1'b1, 1'b1, 0, 100);
        idle(1);
        burst(DEPTH, 1'b1, 1'b1, 200, 300);
        wait_done("tight_done_seen", 0, 400);
        idle(5);
        check("tight_count", 64'(wcnt[0]), 64'd184);
        check_range("tight_rows01", 0, 0, 45, 1, 0);
        check_range("tight_row1", 0, 46, 91, 1, 100);
        check_range("tight_row2", 0, 92, 137, 1, 200);
        check_range("tight_row3", 0, 138, 183, 1, 300);
        check("tight_overflow", 64'(if_m.overflow), 64'd0);
        check("tight_done_once", 64'(dcnt[0]), 64'd1);
        check("tight_done_after_write", 64'(done_cyc[0] > last_wr_cyc[0]), 64'd1);
        check("tight_idle_busy", 64'(if_m.busy), 64'd0);

        // Odd tail: dual burst then a port0-only burst completes the 3-row instance
        clear_logs();
        do_start();
        burst(DEPTH, 1'b1, 1'b1, 0, 100);
        idle(1);
        burst(DEPTH, 1'b1, 1'b0, 500, 0);
        wait_done("tail_done_seen", 1, 400);
        idle(5);
        check("tail_count", 64'(wcnt[1]), 64'd138);
        check_range("tail_row0", 1, 0, 45, 1, 0);
        check_range("tail_row1", 1, 46, 91, 1, 100);
        check_range("tail_row2", 1, 92, 137, 1, 500);
        check("tail_done_once", 64'(dcnt[1]), 64'd1);
        check("tail_4row_busy", 64'(if_m.busy), 64'd1);
        check("tail_4row_no_done", 64'(dcnt[0]), 64'd0);

        // Overflow on the 32-entry instance: port1 of columns 30..45 is dropped
        clear_logs();
        do_start();
        burst(DEPTH, 1'b1, 1'b1, 0, 100);
        idle(80);
        check("ovf_flag", 64'(if_o.overflow), 64'd1);
        check("ovf_count", 64'(wcnt[2]), 64'd76);
        check_range("ovf_port0_all", 2, 0, 45, 1, 0);
        check_range("ovf_port1_kept", 2, 46, 75, 1, 100);
        check_range("ovf_port1_dropped", 2, 76, 91, 0, 0);
        check("ovf_big_fifo_clean", 64'(if_m.overflow), 64'd0);
        do_start();
        check("ovf_cleared_by_start", 64'(if_o.overflow), 64'd0);

        // Asynchronous reset mid-run with data queued
        clear_logs();
        do_start();
        for (int c = 0; c < 40; c++) drive(1'b1, DATA_W'(c + 1), 1'b1, DATA_W'(c + 77));
        check("pre_reset_ovf", 64'(if_o.overflow), 64'd1);
        rst_n = 1'b0;
        #2;
        check("rst_mem_we",    64'(if_m.mem_we),    64'd0);
        check("rst_mem_addr",  64'(if_m.mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(if_m.mem_wdata), 64'd0);
        check("rst_busy",      64'(if_m.busy),      64'd0);
        check("rst_overflow",  64'(if_o.overflow),  64'd0);
        step();
        clear_logs();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) drive(1'b1, DATA_W'(c), 1'b1, DATA_W'(c));
        idle(6);
        check("post_rst_no_write", 64'(wcnt[0] + wcnt[2]), 64'd0);
        check("post_rst_no_done",  64'(dcnt[0]), 64'd0);
        check("post_rst_idle",     64'(if_m.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
